// File: rtl/axi_slave_mem.sv
// axi_slave_mem: AXI4 memory-backed slave, FIXED/INCR bursts, one outstanding write and one outstanding read.
// Optional macro AXI_SLAVE_STALL_EN adds LFSR-driven backpressure on wready and rvalid.
// Ports:
//   axi_aclk, axi_reset               clock, synchronous active-high reset
//   axi_aw*  (id/addr/len/burst)      write address channel, valid/ready handshake
//   axi_w*   (data/strb/last)         write data channel, valid/ready handshake
//   axi_b*   (id/resp)                write response channel, valid/ready handshake
//   axi_ar*  (id/addr/len/burst)      read address channel, valid/ready handshake
//   axi_r*   (id/data/resp/last)      read data channel, valid/ready handshake
module axi_slave_mem #(
    parameter int ASIZE     = 32,
    parameter int DSIZE     = 64,
    parameter int LSIZE     = 8,
    parameter int IDSIZE    = 4,
    parameter int MEM_DEPTH = 1024
) (
    input  logic                axi_aclk,
    input  logic                axi_reset,
    input  logic [IDSIZE-1:0]   axi_awid,
    input  logic [ASIZE-1:0]    axi_awaddr,
    input  logic [LSIZE-1:0]    axi_awlen,
    input  logic [1:0]          axi_awburst,
    input  logic                axi_awvalid,
    output logic                axi_awready,
    input  logic [DSIZE-1:0]    axi_wdata,
    input  logic [DSIZE/8-1:0]  axi_wstrb,
    input  logic                axi_wlast,
    input  logic                axi_wvalid,
    output logic                axi_wready,
    output logic [IDSIZE-1:0]   axi_bid,
    output logic [1:0]          axi_bresp,
    output logic                axi_bvalid,
    input  logic                axi_bready,
    input  logic [IDSIZE-1:0]   axi_arid,
    input  logic [ASIZE-1:0]    axi_araddr,
    input  logic [LSIZE-1:0]    axi_arlen,
    input  logic [1:0]          axi_arburst,
    input  logic                axi_arvalid,
    output logic                axi_arready,
    output logic [IDSIZE-1:0]   axi_rid,
    output logic [DSIZE-1:0]    axi_rdata,
    output logic [1:0]          axi_rresp,
    output logic                axi_rlast,
    output logic                axi_rvalid,
    input  logic                axi_rready
);
    localparam int NB = DSIZE / 8;
    localparam int OB = $clog2(NB);
    localparam int SB = $clog2(MEM_DEPTH * NB);
    localparam logic [ASIZE-1:0] STEP = ASIZE'(NB);

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
    typedef enum logic {R_IDLE, R_DATA} r_state_t;

    logic [DSIZE-1:0] mem [MEM_DEPTH];
    logic stall;

`ifdef AXI_SLAVE_STALL_EN
    logic [7:0] lfsr;
    always_ff @(posedge axi_aclk)
        if (axi_reset) lfsr <= 8'hA5;
        else           lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
    assign stall = lfsr[1:0] == 2'b00;
`else
    assign stall = 1'b0;
`endif

    w_state_t          w_state, w_next;
    logic [IDSIZE-1:0] w_id;
    logic [ASIZE-1:0]  w_addr;
    logic [LSIZE-1:0]  w_len, w_cnt;
    logic [1:0]        w_burst, w_err, w_beat_err;
    logic              aw_hs, w_hs, b_hs, w_beat_last, w_oor, w_done;

    assign axi_awready = w_state == W_IDLE;
    assign axi_wready  = w_state == W_DATA && !stall;
    assign axi_bvalid  = w_state == W_RESP;
    assign axi_bid     = w_id;
    assign axi_bresp   = w_err;
    assign aw_hs       = axi_awvalid && axi_awready;
    assign w_hs        = axi_wvalid && axi_wready;
    assign b_hs        = axi_bvalid && axi_bready;
    assign w_beat_last = w_cnt == w_len;
    assign w_oor       = |w_addr[ASIZE-1:SB];
    assign w_done      = w_hs && (axi_wlast || w_beat_last);
    // wlast disagreeing with the beat count is a protocol error on that beat
    assign w_beat_err  = w_oor ? 2'b11 : (w_burst[1] || axi_wlast != w_beat_last) ? 2'b10 : 2'b00;

    always_comb begin
        w_next = w_state;
        w_next = w_state == W_IDLE ? (aw_hs ? W_DATA : W_IDLE) :
                 w_state == W_DATA ? (w_done ? W_RESP : W_DATA) :
                                     (b_hs ? W_IDLE : W_RESP);
    end

    always_ff @(posedge axi_aclk) begin
        if (axi_reset) begin
            w_state <= W_IDLE;
            w_id    <= '0;
            w_addr  <= '0;
            w_len   <= '0;
            w_burst <= '0;
            w_cnt   <= '0;
            w_err   <= '0;
        end else begin
            w_state <= w_next;
            if (aw_hs) begin
                w_id    <= axi_awid;
                w_addr  <= axi_awaddr;
                w_len   <= axi_awlen;
                w_burst <= axi_awburst;
                w_cnt   <= '0;
                w_err   <= '0;
            end
            if (w_hs) begin
                w_cnt  <= w_cnt + LSIZE'(1);
                w_addr <= w_burst == 2'b01 ? w_addr + STEP : w_addr;
                // codes are ordered so the numerically larger one is the worse error
                if (w_beat_err > w_err) w_err <= w_beat_err;
            end
        end
    end

    always_ff @(posedge axi_aclk)
        if (w_hs && !w_oor && !w_burst[1] && !axi_reset)
            for (int i = 0; i < NB; i++)
                if (axi_wstrb[i]) mem[w_addr[SB-1:OB]][8*i +: 8] <= axi_wdata[8*i +: 8];

    r_state_t          r_state, r_next;
    logic [IDSIZE-1:0] r_id;
    logic [ASIZE-1:0]  r_addr, ld_addr;
    logic [LSIZE-1:0]  r_len, r_cnt, ld_cnt, ld_len;
    logic [1:0]        r_burst, ld_burst, ld_err, r_resp;
    logic [DSIZE-1:0]  r_data;
    logic              r_last, ar_hs, r_hs, ld;

    assign axi_arready = r_state == R_IDLE;
    assign axi_rvalid  = r_state == R_DATA && !stall;
    assign axi_rid     = r_id;
    assign axi_rdata   = r_data;
    assign axi_rresp   = r_resp;
    assign axi_rlast   = r_last;
    assign ar_hs       = axi_arvalid && axi_arready;
    assign r_hs        = axi_rvalid && axi_rready;
    // the beat to present next is fetched on the same edge that accepts AR or consumes the current beat
    assign ld          = ar_hs || (r_hs && !r_last);
    assign ld_addr     = ar_hs ? axi_araddr : (r_burst == 2'b01 ? r_addr + STEP : r_addr);
    assign ld_burst    = ar_hs ? axi_arburst : r_burst;
    assign ld_cnt      = ar_hs ? '0 : r_cnt + LSIZE'(1);
    assign ld_len      = ar_hs ? axi_arlen : r_len;
    assign ld_err      = |ld_addr[ASIZE-1:SB] ? 2'b11 : ld_burst[1] ? 2'b10 : 2'b00;

    always_comb begin
        r_next = r_state;
        r_next = r_state == R_IDLE ? (ar_hs ? R_DATA : R_IDLE) : (r_hs && r_last ? R_IDLE : R_DATA);
    end

    always_ff @(posedge axi_aclk) begin
        if (axi_reset) begin
            r_state <= R_IDLE;
            r_id    <= '0;
            r_addr  <= '0;
            r_len   <= '0;
            r_burst <= '0;
            r_cnt   <= '0;
            r_data  <= '0;
            r_resp  <= '0;
            r_last  <= 1'b0;
        end else begin
            r_state <= r_next;
            if (ar_hs) begin
                r_id    <= axi_arid;
                r_len   <= axi_arlen;
                r_burst <= axi_arburst;
            end
            if (ld) begin
                r_addr <= ld_addr;
                r_cnt  <= ld_cnt;
                r_resp <= ld_err;
                r_last <= ld_cnt == ld_len;
                r_data <= ld_err == 2'b00 ? mem[ld_addr[SB-1:OB]] : '0;
            end else if (r_hs) begin
                r_last <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_axi_slave_mem.sv
// tb_axi_slave_mem: self-checking bench for axi_slave_mem; read beats are checked against a scoreboard queue.
module tb_axi_slave_mem;
    logic        axi_aclk = 1'b0, axi_reset = 1'b1;
    logic [3:0]  axi_awid = '0, axi_arid = '0;
    logic [31:0] axi_awaddr = '0, axi_araddr = '0;
    logic [7:0]  axi_awlen = '0, axi_arlen = '0;
    logic [1:0]  axi_awburst = '0, axi_arburst = '0;
    logic        axi_awvalid = 1'b0, axi_wlast = 1'b0, axi_wvalid = 1'b0, axi_bready = 1'b0;
    logic        axi_arvalid = 1'b0, axi_rready = 1'b0;
    logic [63:0] axi_wdata = '0;
    logic [7:0]  axi_wstrb = '0;
    logic        axi_awready, axi_wready, axi_bvalid, axi_arready, axi_rlast, axi_rvalid;
    logic [3:0]  axi_bid, axi_rid;
    logic [1:0]  axi_bresp, axi_rresp;
    logic [63:0] axi_rdata;

    typedef struct packed {
        logic [3:0]  id;
        logic [63:0] data;
        logic [1:0]  resp;
        logic        last;
    } beat_t;

    localparam logic [31:0] SPAN = 32'h2000;
    beat_t       exp_q[$];
    logic [63:0] model [int];
    int          checks = 0, errors = 0;

    axi_slave_mem dut (
        .axi_aclk(axi_aclk), .axi_reset(axi_reset),
        .axi_awid(axi_awid), .axi_awaddr(axi_awaddr), .axi_awlen(axi_awlen), .axi_awburst(axi_awburst),
        .axi_awvalid(axi_awvalid), .axi_awready(axi_awready),
        .axi_wdata(axi_wdata), .axi_wstrb(axi_wstrb), .axi_wlast(axi_wlast), .axi_wvalid(axi_wvalid),
        .axi_wready(axi_wready),
        .axi_bid(axi_bid), .axi_bresp(axi_bresp), .axi_bvalid(axi_bvalid), .axi_bready(axi_bready),
        .axi_arid(axi_arid), .axi_araddr(axi_araddr), .axi_arlen(axi_arlen), .axi_arburst(axi_arburst),
        .axi_arvalid(axi_arvalid), .axi_arready(axi_arready),
        .axi_rid(axi_rid), .axi_rdata(axi_rdata), .axi_rresp(axi_rresp), .axi_rlast(axi_rlast),
        .axi_rvalid(axi_rvalid), .axi_rready(axi_rready)
    );

    always #5 axi_aclk = ~axi_aclk;

    initial begin
        #500000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    // every accepted read beat is compared against the oldest expected beat
    always @(negedge axi_aclk) begin
        beat_t e;
        if (!axi_reset && axi_rvalid === 1'b1 && axi_rready) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL r_unexpected got data=%h resp=%b, no beat expected", axi_rdata, axi_rresp);
            end else begin
                e = exp_q.pop_front();
                if ({axi_rid, axi_rdata, axi_rresp, axi_rlast} !== e) begin
                    errors++;
                    $display("FAIL r_beat got id=%h data=%h resp=%b last=%b need id=%h data=%h resp=%b last=%b",
                             axi_rid, axi_rdata, axi_rresp, axi_rlast, e.id, e.data, e.resp, e.last);
                end
            end
        end
    end

    function automatic void model_write(input logic [31:0] a, input logic [63:0] d, input logic [7:0] s,
                                        input logic [1:0] burst);
        logic [63:0] w;
        if (a < SPAN && !burst[1]) begin
            w = model.exists(int'(a >> 3)) ? model[int'(a >> 3)] : 64'd0;
            for (int b = 0; b < 8; b++) if (s[b]) w[8*b +: 8] = d[8*b +: 8];
            model[int'(a >> 3)] = w;
        end
    endfunction

    function automatic void push_read(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                                      input logic [1:0] burst);
        logic [31:0] a;
        beat_t b;
        a = addr;
        for (int i = 0; i <= int'(len); i++) begin
            b.id   = id;
            b.resp = (a >= SPAN) ? 2'b11 : burst[1] ? 2'b10 : 2'b00;
            b.data = (b.resp == 2'b00 && model.exists(int'(a >> 3))) ? model[int'(a >> 3)] : 64'd0;
            b.last = (i == int'(len));
            exp_q.push_back(b);
            if (burst == 2'b01) a = a + 32'd8;
        end
    endfunction

    task automatic w_burst(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                           input logic [1:0] burst, input int nbeats, input logic [63:0] base, input logic [7:0] strb);
        bit hs;
        logic [31:0] a;
        hs = 0;
        axi_awid = id; axi_awaddr = addr; axi_awlen = len; axi_awburst = burst; axi_awvalid = 1'b1;
        for (int t = 0; t < 50 && !hs; t++) begin
            @(negedge axi_aclk); hs = axi_awready;
            @(posedge axi_aclk); #1;
        end
        axi_awvalid = 1'b0;
        if (!hs) begin checks++; errors++; $display("FAIL aw_timeout awready=%b need 1", axi_awready); end
        a = addr;
        for (int i = 0; i < nbeats; i++) begin
            axi_wdata = base + 64'(i); axi_wstrb = strb; axi_wlast = (i == nbeats - 1); axi_wvalid = 1'b1;
            hs = 0;
            for (int t = 0; t < 50 && !hs; t++) begin
                @(negedge axi_aclk); hs = axi_wready;
                @(posedge axi_aclk); #1;
            end
            if (!hs) begin checks++; errors++; $display("FAIL w_timeout beat %0d wready=%b need 1", i, axi_wready); end
            model_write(a, base + 64'(i), strb, burst);
            if (burst == 2'b01) a = a + 32'd8;
        end
        axi_wvalid = 1'b0; axi_wlast = 1'b0;
    endtask

    task automatic b_take(output logic [3:0] id, output logic [1:0] resp);
        bit hs;
        hs = 0; id = 'x; resp = 'x;
        axi_bready = 1'b1;
        for (int t = 0; t < 50 && !hs; t++) begin
            @(negedge axi_aclk);
            hs = axi_bvalid;
            if (hs) begin id = axi_bid; resp = axi_bresp; end
            @(posedge axi_aclk); #1;
        end
        axi_bready = 1'b0;
        if (!hs) begin checks++; errors++; $display("FAIL b_timeout bvalid=%b need 1", axi_bvalid); end
    endtask

    task automatic do_write(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                            input logic [1:0] burst, input int nbeats, input logic [63:0] base, input logic [7:0] strb,
                            output logic [3:0] bid, output logic [1:0] bresp);
        w_burst(id, addr, len, burst, nbeats, base, strb);
        b_take(bid, bresp);
    endtask

    task automatic ar_send(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len, input logic [1:0] burst);
        bit hs;
        hs = 0;
        axi_arid = id; axi_araddr = addr; axi_arlen = len; axi_arburst = burst; axi_arvalid = 1'b1;
        for (int t = 0; t < 50 && !hs; t++) begin
            @(negedge axi_aclk); hs = axi_arready;
            @(posedge axi_aclk); #1;
        end
        axi_arvalid = 1'b0;
        if (!hs) begin checks++; errors++; $display("FAIL ar_timeout arready=%b need 1", axi_arready); end
    endtask

    task automatic wait_drain();
        axi_rready = 1'b1;
        for (int t = 0; t < 300 && exp_q.size() != 0; t++) begin
            @(negedge axi_aclk); #1;
        end
        @(posedge axi_aclk); #1;
        if (exp_q.size() != 0) begin
            checks++; errors++;
            $display("FAIL r_timeout %0d beats outstanding, need 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic do_read(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len, input logic [1:0] burst);
        push_read(id, addr, len, burst);
        axi_rready = 1'b1;
        ar_send(id, addr, len, burst);
        wait_drain();
    endtask

    task automatic test_reset();
        axi_reset = 1'b1;
        repeat (3) @(posedge axi_aclk);
        @(negedge axi_aclk);
        checks++;
        if ({axi_awready, axi_arready} !== 2'b11) begin
            errors++; $display("FAIL reset_ready got aw/ar=%b%b need 11", axi_awready, axi_arready);
        end
        checks++;
        if ({axi_wready, axi_bvalid, axi_rvalid, axi_rlast} !== 4'b0) begin
            errors++; $display("FAIL reset_valid got w/b/r/last=%b%b%b%b need 0000", axi_wready, axi_bvalid, axi_rvalid, axi_rlast);
        end
        checks++;
        if ({axi_bid, axi_bresp, axi_rid, axi_rresp, axi_rdata} !== 76'd0) begin
            errors++; $display("FAIL reset_fields got bid=%h bresp=%b rid=%h rresp=%b rdata=%h need 0", axi_bid, axi_bresp, axi_rid, axi_rresp, axi_rdata);
        end
        @(posedge axi_aclk); #1;
        axi_reset = 1'b0;
    endtask

    task automatic test_incr();
        logic [3:0] bid;
        logic [1:0] bresp;
        do_write(4'h5, 32'h100, 8'd3, 2'b01, 4, 64'd1, 8'hFF, bid, bresp);
        checks++;
        if (bresp !== 2'b00 || bid !== 4'h5) begin
            errors++; $display("FAIL incr_b got bid=%h bresp=%b need bid=5 bresp=00", bid, bresp);
        end
        do_read(4'h9, 32'h100, 8'd3, 2'b01);
    endtask

    task automatic test_fixed();
        logic [3:0] bid;
        logic [1:0] bresp;
        do_write(4'h2, 32'h40, 8'd2, 2'b00, 3, 64'hA, 8'hFF, bid, bresp);
        checks++;
        if (bresp !== 2'b00 || bid !== 4'h2) begin
            errors++; $display("FAIL fixed_b got bid=%h bresp=%b need bid=2 bresp=00", bid, bresp);
        end
        do_read(4'h3, 32'h40, 8'd0, 2'b00);
    endtask

    task automatic test_strobe();
        logic [3:0] bid;
        logic [1:0] bresp;
        do_write(4'h1, 32'h80, 8'd0, 2'b01, 1, 64'hFFFFFFFF_FFFFFFFF, 8'hFF, bid, bresp);
        do_write(4'h1, 32'h80, 8'd0, 2'b01, 1, 64'd0, 8'h0F, bid, bresp);
        checks++;
        if (bresp !== 2'b00) begin errors++; $display("FAIL strobe_b got bresp=%b need 00", bresp); end
        exp_q.push_back('{4'h4, 64'hFFFFFFFF_00000000, 2'b00, 1'b1});
        axi_rready = 1'b1;
        ar_send(4'h4, 32'h80, 8'd0, 2'b01);
        wait_drain();
    endtask

    task automatic test_decerr();
        logic [3:0] bid;
        logic [1:0] bresp;
        do_write(4'h4, 32'h0, 8'd0, 2'b01, 1, 64'h1234, 8'hFF, bid, bresp);
        do_write(4'h6, SPAN, 8'd1, 2'b01, 2, 64'hDEAD, 8'hFF, bid, bresp);
        checks++;
        if (bresp !== 2'b11 || bid !== 4'h6) begin
            errors++; $display("FAIL decerr_b got bid=%h bresp=%b need bid=6 bresp=11", bid, bresp);
        end
        do_read(4'h7, SPAN, 8'd1, 2'b01);
        do_read(4'h7, 32'h0, 8'd0, 2'b01);
    endtask

    task automatic test_slverr();
        logic [3:0] bid;
        logic [1:0] bresp;
        do_write(4'h8, 32'h200, 8'd0, 2'b01, 1, 64'h77, 8'hFF, bid, bresp);
        do_write(4'h8, 32'h200, 8'd1, 2'b11, 2, 64'h55, 8'hFF, bid, bresp);
        checks++;
        if (bresp !== 2'b10) begin errors++; $display("FAIL slverr_burst got bresp=%b need 10", bresp); end
        do_read(4'h8, 32'h200, 8'd0, 2'b01);
        do_read(4'h8, 32'h200, 8'd1, 2'b10);
        do_write(4'h9, 32'h300, 8'd3, 2'b01, 2, 64'h10, 8'hFF, bid, bresp);
        checks++;
        if (bresp !== 2'b10 || bid !== 4'h9) begin
            errors++; $display("FAIL early_wlast got bid=%h bresp=%b need bid=9 bresp=10", bid, bresp);
        end
        @(negedge axi_aclk);
        checks++;
        if (axi_awready !== 1'b1 || axi_wready !== 1'b0) begin
            errors++; $display("FAIL early_wlast_idle got awready=%b wready=%b need 1 0", axi_awready, axi_wready);
        end
        @(posedge axi_aclk); #1;
    endtask

    task automatic test_bready_stall();
        logic [3:0] bid;
        logic [1:0] bresp;
        w_burst(4'h3, 32'h400, 8'd1, 2'b01, 2, 64'h40, 8'hFF);
        for (int i = 0; i < 3; i++) begin
            @(negedge axi_aclk);
            checks++;
            if (axi_bvalid !== 1'b1 || axi_awready !== 1'b0 || axi_bid !== 4'h3 || axi_bresp !== 2'b00) begin
                errors++;
                $display("FAIL bready_hold cyc %0d got bvalid=%b awready=%b bid=%h bresp=%b need 1 0 3 00",
                         i, axi_bvalid, axi_awready, axi_bid, axi_bresp);
            end
            @(posedge axi_aclk); #1;
        end
        b_take(bid, bresp);
        checks++;
        if (bresp !== 2'b00 || bid !== 4'h3) begin
            errors++; $display("FAIL bready_resp got bid=%h bresp=%b need bid=3 bresp=00", bid, bresp);
        end
        do_read(4'h3, 32'h400, 8'd1, 2'b01);
    endtask

    task automatic test_rready_stall();
        push_read(4'hC, 32'h100, 8'd3, 2'b01);
        axi_rready = 1'b1;
        ar_send(4'hC, 32'h100, 8'd3, 2'b01);
        for (int t = 0; t < 50 && exp_q.size() > 2; t++) begin
            @(negedge axi_aclk); #1;
        end
        @(posedge axi_aclk); #1;
        axi_rready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge axi_aclk);
            checks++;
            if (exp_q.size() == 0) begin
                errors++; $display("FAIL rready_hold cyc %0d got no beat pending, need one", i);
            end else if (axi_rvalid !== 1'b1 || axi_rdata !== exp_q[0].data || axi_rlast !== exp_q[0].last) begin
                errors++;
                $display("FAIL rready_hold cyc %0d got rvalid=%b rdata=%h rlast=%b need 1 %h %b",
                         i, axi_rvalid, axi_rdata, axi_rlast, exp_q[0].data, exp_q[0].last);
            end
        end
        @(posedge axi_aclk); #1;
        wait_drain();
    endtask

    task automatic test_reset_mid_read();
        logic [3:0] bid;
        logic [1:0] bresp;
        do_write(4'h1, 32'h600, 8'd7, 2'b01, 8, 64'h600, 8'hFF, bid, bresp);
        push_read(4'h2, 32'h600, 8'd7, 2'b01);
        axi_rready = 1'b1;
        ar_send(4'h2, 32'h600, 8'd7, 2'b01);
        for (int t = 0; t < 50 && exp_q.size() > 7; t++) begin
            @(negedge axi_aclk); #1;
        end
        @(posedge axi_aclk); #1;
        axi_reset = 1'b1;
        @(posedge axi_aclk); #1;
        axi_reset = 1'b0;
        exp_q.delete();
        @(negedge axi_aclk);
        checks++;
        if (axi_rvalid !== 1'b0 || axi_arready !== 1'b1) begin
            errors++; $display("FAIL reset_mid_read got rvalid=%b arready=%b need 0 1", axi_rvalid, axi_arready);
        end
        @(posedge axi_aclk); #1;
        do_read(4'h5, 32'h600, 8'd7, 2'b01);
    endtask

    task automatic test_back_to_back();
        logic [3:0] bid;
        logic [1:0] bresp;
        fork
            do_write(4'hA, 32'h700, 8'd3, 2'b01, 4, 64'h70, 8'hFF, bid, bresp);
            do_read(4'hB, 32'h100, 8'd3, 2'b01);
        join
        checks++;
        if (bresp !== 2'b00 || bid !== 4'hA) begin
            errors++; $display("FAIL concurrent_b got bid=%h bresp=%b need bid=a bresp=00", bid, bresp);
        end
        do_read(4'hD, 32'h700, 8'd3, 2'b01);
    endtask

    initial begin
        test_reset();
        test_incr();
        test_fixed();
        test_strobe();
        test_decerr();
        test_slverr();
        test_bready_stall();
        test_rready_stall();
        test_reset_mid_read();
        test_back_to_back();
        repeat (3) @(posedge axi_aclk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
